// File: rtl/rgb_fade_ctrl.sv
// Three-channel level fader: walks each PWM level one LSB toward its target
// every (rate+1) frame_start pulses, then pulses done once all channels land.
module rgb_fade_ctrl #(
    parameter int WIDTH      = 8,
    parameter int RATE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic [RATE_WIDTH-1:0] rate,
    input  logic [WIDTH-1:0]      target0,
    input  logic [WIDTH-1:0]      target1,
    input  logic [WIDTH-1:0]      target2,
    output logic [WIDTH-1:0]      level0,
    output logic [WIDTH-1:0]      level1,
    output logic [WIDTH-1:0]      level2,
    output logic                  busy,
    output logic                  done
);

    localparam int NUM_CH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FADE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [RATE_WIDTH-1:0] r_frame_cnt;
    logic [WIDTH-1:0]      r_level [NUM_CH];
    logic                  r_busy;
    logic                  r_done;

    logic [WIDTH-1:0]      w_target     [NUM_CH];
    logic [WIDTH-1:0]      w_step_level [NUM_CH];
    logic [NUM_CH-1:0]     w_mismatch;
    logic [NUM_CH-1:0]     w_step_hit;

    assign w_target[0] = target0;
    assign w_target[1] = target1;
    assign w_target[2] = target2;

    // Candidate next level per channel: one LSB toward the live target, so it
    // can never overshoot or wrap past 0 / all-ones.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_step_level[gi] =
                (r_level[gi] < w_target[gi]) ? r_level[gi] + WIDTH'(1) :
                (r_level[gi] > w_target[gi]) ? r_level[gi] - WIDTH'(1) :
                                               r_level[gi];
            assign w_mismatch[gi] = (r_level[gi] != w_target[gi]);
            assign w_step_hit[gi] = (w_step_level[gi] == w_target[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_level[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // frame_start on the entry edge is deliberately not counted
                    if (enable && (|w_mismatch)) begin
                        r_state     <= FADE;
                        r_frame_cnt <= rate;
                        r_busy      <= 1'b1;
                    end
                end
                FADE: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (frame_start) begin
                        if (r_frame_cnt != '0) begin
                            r_frame_cnt <= r_frame_cnt - RATE_WIDTH'(1);
                        end else begin
                            r_frame_cnt <= rate;
                            for (int i = 0; i < NUM_CH; i++) begin
                                r_level[i] <= w_step_level[i];
                            end
                            if (&w_step_hit) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign level0 = r_level[0];
    assign level1 = r_level[1];
    assign level2 = r_level[2];
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Self-checking bench for rgb_fade_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural fade model.
module tb_rgb_fade_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_start;
    logic [7:0] rate;
    logic [7:0] target0, target1, target2;
    logic [7:0] level0, level1, level2;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase 0=idle 1=fading 2=done; a step happens on the
    // period-th counted frame, period latched as rate+1 when a period begins.
    int m_phase  = 0;
    int m_lvl [3];
    int m_frames = 0;
    int m_period = 1;

    typedef struct {
        int rst_n, en, fs, rate, t0, t1, t2;
        int l0, l1, l2, busy, done;
    } vec_t;

    vec_t vecs [14];

    rgb_fade_ctrl #(.WIDTH(8), .RATE_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .rate        (rate),
        .target0     (target0),
        .target1     (target1),
        .target2     (target2),
        .level0      (level0),
        .level1      (level1),
        .level2      (level2),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mkv(int rst_n, int en, int fs, int rt, int t0, int t1, int t2,
                                 int l0, int l1, int l2, int b, int d);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.fs = fs; v.rate = rt;
        v.t0 = t0; v.t1 = t1; v.t2 = t2;
        v.l0 = l0; v.l1 = l1; v.l2 = l2; v.busy = b; v.done = d;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int tg [3];
        bit all_eq;
        bit any_ne;
        tg[0] = int'(target0); tg[1] = int'(target1); tg[2] = int'(target2);
        if (!reset) begin
            m_phase = 0; m_frames = 0;
            for (int i = 0; i < 3; i++) m_lvl[i] = 0;
        end else begin
            case (m_phase)
                0: begin
                    any_ne = 0;
                    for (int i = 0; i < 3; i++) if (m_lvl[i] != tg[i]) any_ne = 1;
                    if (enable && any_ne) begin
                        m_phase = 1; m_frames = 0; m_period = int'(rate) + 1;
                    end
                end
                1: begin
                    if (!enable) begin
                        m_phase = 0;
                    end else if (frame_start) begin
                        m_frames++;
                        if (m_frames == m_period) begin
                            all_eq = 1;
                            for (int i = 0; i < 3; i++) begin
                                if (m_lvl[i] < tg[i]) m_lvl[i]++;
                                else if (m_lvl[i] > tg[i]) m_lvl[i]--;
                                if (m_lvl[i] != tg[i]) all_eq = 0;
                            end
                            m_frames = 0;
                            m_period = int'(rate) + 1;
                            if (all_eq) m_phase = 2;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("model_level0", int'(level0), m_lvl[0]);
        check("model_level1", int'(level1), m_lvl[1]);
        check("model_level2", int'(level2), m_lvl[2]);
        check("model_busy", int'(busy), int'(m_phase == 1));
        check("model_done", int'(done), int'(m_phase == 2));
    endtask

    task automatic fs_tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic idle_tick();
        frame_start = 1'b0; tick();
    endtask

    task automatic do_reset();
        reset = 1'b0; frame_start = 1'b0; tick(); reset = 1'b1;
    endtask

    initial begin
        int exp_l0, done_cnt;

        reset = 1'b0; enable = 1'b0; frame_start = 1'b0; rate = 8'd0;
        target0 = 8'd0; target1 = 8'd0; target2 = 8'd0;

        //          rst en fs rt t0 t1 t2  l0 l1 l2 b  d
        vecs[0]  = mkv(0, 0, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = mkv(1, 1, 1, 0, 3, 0, 0,  0, 0, 0, 1, 0);
        vecs[2]  = mkv(1, 1, 0, 0, 3, 0, 0,  0, 0, 0, 1, 0);
        vecs[3]  = mkv(1, 1, 1, 0, 3, 0, 0,  1, 0, 0, 1, 0);
        vecs[4]  = mkv(1, 1, 0, 0, 3, 0, 0,  1, 0, 0, 1, 0);
        vecs[5]  = mkv(1, 1, 1, 0, 3, 0, 0,  2, 0, 0, 1, 0);
        vecs[6]  = mkv(1, 1, 1, 0, 3, 0, 0,  3, 0, 0, 0, 1);
        vecs[7]  = mkv(1, 1, 1, 0, 3, 0, 0,  3, 0, 0, 0, 0);
        vecs[8]  = mkv(1, 1, 0, 0, 1, 0, 0,  3, 0, 0, 1, 0);
        vecs[9]  = mkv(1, 0, 1, 0, 1, 0, 0,  3, 0, 0, 0, 0);
        vecs[10] = mkv(1, 1, 0, 0, 1, 0, 0,  3, 0, 0, 1, 0);
        vecs[11] = mkv(1, 1, 1, 0, 1, 0, 0,  2, 0, 0, 1, 0);
        vecs[12] = mkv(0, 1, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
        vecs[13] = mkv(1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);

        for (int v = 0; v < 14; v++) begin
            reset = vecs[v].rst_n[0]; enable = vecs[v].en[0]; frame_start = vecs[v].fs[0];
            rate = 8'(vecs[v].rate);
            target0 = 8'(vecs[v].t0); target1 = 8'(vecs[v].t1); target2 = 8'(vecs[v].t2);
            tick();
            check($sformatf("vec%0d_level0", v), int'(level0), vecs[v].l0);
            check($sformatf("vec%0d_level1", v), int'(level1), vecs[v].l1);
            check($sformatf("vec%0d_level2", v), int'(level2), vecs[v].l2);
            check($sformatf("vec%0d_busy", v), int'(busy), vecs[v].busy);
            check($sformatf("vec%0d_done", v), int'(done), vecs[v].done);
            $display("vec %0d: rst=%0d en=%0d fs=%0d t0=%0d -> level0=%0d busy=%0d done=%0d",
                     v, vecs[v].rst_n, vecs[v].en, vecs[v].fs, vecs[v].t0, level0, busy, done);
        end

        // Slow rate: rate=2 steps on the 3rd and 6th pulse after entering FADE.
        do_reset();
        enable = 1'b1; rate = 8'd2; target0 = 8'd2; target1 = 8'd0; target2 = 8'd0;
        idle_tick();
        check("rate2_busy_entry", int'(busy), 1);
        for (int p = 1; p <= 6; p++) begin
            fs_tick();
            exp_l0 = (p >= 6) ? 2 : (p >= 3) ? 1 : 0;
            check($sformatf("rate2_p%0d_level0", p), int'(level0), exp_l0);
            check($sformatf("rate2_p%0d_done", p), int'(done), int'(p == 6));
        end
        idle_tick();
        check("rate2_done_clear", int'(done), 0);
        check("rate2_busy_after", int'(busy), 0);
        $display("seq rate2: level0=%0d busy=%0d done=%0d", level0, busy, done);

        // Mixed directions: 5/0/0 toward 2/4/0, level0 parks at 2.
        do_reset();
        rate = 8'd0; target0 = 8'd5; target1 = 8'd0; target2 = 8'd0;
        idle_tick();
        for (int s = 0; s < 5; s++) fs_tick();
        check("mix_pre_level0", int'(level0), 5);
        check("mix_pre_done", int'(done), 1);
        idle_tick();
        target0 = 8'd2; target1 = 8'd4;
        idle_tick();
        for (int s = 1; s <= 4; s++) begin
            fs_tick();
            check($sformatf("mix_s%0d_level0", s), int'(level0), (5 - s < 2) ? 2 : 5 - s);
            check($sformatf("mix_s%0d_level1", s), int'(level1), s);
            check($sformatf("mix_s%0d_done", s), int'(done), int'(s == 4));
        end
        $display("seq mix: level0=%0d level1=%0d done=%0d", level0, level1, done);

        // Direction reversal mid-fade: 0 -> 10, retarget to 1 at level 4.
        do_reset();
        rate = 8'd0; target0 = 8'd10; target1 = 8'd0; target2 = 8'd0;
        idle_tick();
        for (int s = 0; s < 4; s++) fs_tick();
        check("rev_mid_level0", int'(level0), 4);
        target0 = 8'd1;
        done_cnt = 0;
        for (int s = 1; s <= 5; s++) begin
            fs_tick();
            if (done) done_cnt++;
            check($sformatf("rev_s%0d_level0", s), int'(level0), (s <= 3) ? 4 - s : 1);
        end
        check("rev_done_count", done_cnt, 1);
        $display("seq reverse: level0=%0d done_pulses=%0d", level0, done_cnt);

        // Enable drop mid-fade holds the level and suppresses done.
        do_reset();
        rate = 8'd0; target0 = 8'd20; target1 = 8'd0; target2 = 8'd0;
        idle_tick();
        for (int s = 0; s < 6; s++) fs_tick();
        check("en_mid_level0", int'(level0), 6);
        enable = 1'b0;
        fs_tick();
        check("en_drop_busy", int'(busy), 0);
        check("en_drop_level0", int'(level0), 6);
        done_cnt = int'(done);
        for (int s = 0; s < 3; s++) begin
            fs_tick();
            if (done) done_cnt++;
        end
        check("en_drop_hold_level0", int'(level0), 6);
        check("en_drop_no_done", done_cnt, 0);
        enable = 1'b1;
        idle_tick();
        check("en_back_busy", int'(busy), 1);
        fs_tick();
        check("en_back_level0", int'(level0), 7);
        $display("seq enable: level0=%0d busy=%0d", level0, busy);

        // Reset mid-fade at level 100 wins over a coincident frame_start.
        do_reset();
        rate = 8'd0; target0 = 8'd200; target1 = 8'd0; target2 = 8'd0;
        idle_tick();
        for (int s = 0; s < 100; s++) fs_tick();
        check("rst_mid_level0", int'(level0), 100);
        check("rst_mid_busy", int'(busy), 1);
        reset = 1'b0; frame_start = 1'b1;
        tick();
        check("rst_level0", int'(level0), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b1; frame_start = 1'b0;
        $display("seq reset: level0=%0d busy=%0d done=%0d", level0, busy, done);

        // Randomized run checked against the model on every cycle.
        for (int seg = 0; seg < 40; seg++) begin
            rate = 8'($urandom_range(0, 3));
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 29) == 0 || c == 0) begin
                    int ch, nt;
                    ch = int'($urandom_range(0, 2));
                    if ($urandom_range(0, 9) == 0)
                        nt = ($urandom_range(0, 1) == 0) ? 0 : 255;
                    else
                        nt = m_lvl[ch] + int'($urandom_range(0, 8)) - 4;
                    if (nt < 0) nt = 0;
                    if (nt > 255) nt = 255;
                    case (ch)
                        0: target0 = 8'(nt);
                        1: target1 = 8'(nt);
                        default: target2 = 8'(nt);
                    endcase
                end
                if ($urandom_range(0, 19) == 0) rate = 8'($urandom_range(0, 3));
                reset       = ($urandom_range(0, 199) != 0);
                enable      = ($urandom_range(0, 19) != 0);
                frame_start = $urandom_range(0, 1) == 1;
                tick();
            end
            $display("rand seg %0d: rate=%0d levels=%0d/%0d/%0d targets=%0d/%0d/%0d busy=%0d",
                     seg, rate, level0, level1, level2, target0, target1, target2, busy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
